// File: rtl/edge_stream_pkg.sv
// rtl/edge_stream_pkg.sv - shared sizes, tags, list type, state encoding and word formatters
package edge_stream_pkg;

  localparam int N_ENTRIES = 30;
  localparam int X_W       = 11;
  localparam logic [4:0] N_ENT5 = 5'(N_ENTRIES);

  localparam logic [3:0] TAG_HDR = 4'hA;
  localparam logic [3:0] TAG_ENT = 4'h5;

  typedef logic [N_ENTRIES-1:0][X_W-1:0] edge_list_t;

  typedef enum logic [1:0] {IDLE, SNAP, HEADER, ENTRY} state_t;

  function automatic logic [31:0] hdr_word(input logic [11:0] fid, input logic [4:0] count);
    return {TAG_HDR, fid, 11'd0, count};
  endfunction

  // Gap is forced to 0 on the last entry and saturates when the next x is not larger.
  function automatic logic [31:0] ent_word(input logic [4:0] idx, input logic [X_W-1:0] x,
                                           input logic [X_W-1:0] x_next, input logic is_last);
    logic [X_W-1:0] gap;
    gap = (!is_last && (x_next > x)) ? (x_next - x) : '0;
    return {TAG_ENT, idx, x, 1'b0, gap};
  endfunction

endpackage

// File: rtl/edge_list_streamer_if.sv
// rtl/edge_list_streamer_if.sv - valid/ready word stream between streamer and host FIFO
interface edge_list_streamer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/edge_list_streamer_count_enc.sv
// rtl/edge_list_streamer_count_enc.sv - edge_count_enc: first-zero-slot priority encoder
module edge_count_enc
  import edge_stream_pkg::*;
(
  input  edge_list_t  list,
  output logic [4:0]  count
);

  // Scanning from the top down leaves the lowest empty slot as the final winner.
  always_comb begin
    count = N_ENT5;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (list[i] == '0) count = 5'(i);
    end
  end

endmodule

// File: rtl/edge_list_streamer.sv
// rtl/edge_list_streamer.sv - snapshots the edge list on sop and drains header + entries
module edge_list_streamer
  import edge_stream_pkg::*;
#(
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sop,
  input  edge_list_t           measured_list,
  edge_list_streamer_if.master out_if,
  output logic                 busy,
  output logic                 overrun,
  output logic [11:0]          frame_id
);

  state_t      state_q, state_d;
  edge_list_t  snap_q, snap_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  idx_q, idx_d;
  logic [11:0] fid_q, fid_d;
  logic [11:0] snap_fid_q, snap_fid_d;
  logic        overrun_q, overrun_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [31:0] data_q, data_d;

  logic [4:0]     enc_count;
  logic           hs;
  logic [4:0]     nxt_idx;
  logic [4:0]     idx_after;
  logic           nxt_last;
  logic [X_W-1:0] x_after;

  edge_count_enc u_enc (
    .list  (snap_q),
    .count (enc_count)
  );

  assign hs        = valid_q && out_if.out_ready;
  assign nxt_idx   = idx_q + 5'd1;
  assign idx_after = idx_q + 5'd2;
  assign nxt_last  = (nxt_idx == count_q - 5'd1);
  assign x_after   = (idx_after < N_ENT5) ? snap_q[idx_after] : '0;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    count_d    = count_q;
    idx_d      = idx_q;
    fid_d      = fid_q;
    snap_fid_d = snap_fid_q;
    overrun_d  = overrun_q;
    valid_d    = valid_q;
    last_d     = last_q;
    data_d     = data_q;

    if (sop) fid_d = fid_q + 12'd1;
    // Any sop outside IDLE is lost, including one that lands on the final handshake.
    if (sop && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sop) begin
          snap_d     = measured_list;
          snap_fid_d = fid_q + 12'd1;
          state_d    = SNAP;
        end
      end
      SNAP: begin
        count_d = enc_count;
        if (enc_count == 5'd0 && !EMIT_EMPTY) begin
          state_d = IDLE;
        end else begin
          state_d = HEADER;
          valid_d = 1'b1;
          last_d  = (enc_count == 5'd0);
          data_d  = hdr_word(snap_fid_q, enc_count);
        end
      end
      HEADER: begin
        if (hs) begin
          if (count_q == 5'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            state_d = ENTRY;
            idx_d   = 5'd0;
            last_d  = (count_q == 5'd1);
            data_d  = ent_word(5'd0, snap_q[0], snap_q[1], count_q == 5'd1);
          end
        end
      end
      ENTRY: begin
        if (hs) begin
          if (idx_q == count_q - 5'd1) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            idx_d  = nxt_idx;
            last_d = nxt_last;
            data_d = ent_word(nxt_idx, snap_q[nxt_idx], x_after, nxt_last);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      fid_q      <= '0;
      snap_fid_q <= '0;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      fid_q      <= fid_d;
      snap_fid_q <= snap_fid_d;
      overrun_q  <= overrun_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = overrun_q;
  assign frame_id         = fid_q;

endmodule

// File: tb/tb_edge_list_streamer.sv
// tb/tb_edge_list_streamer.sv - randomized and directed checks against a list-level model
module tb_edge_list_streamer;
  import edge_stream_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sop = 1'b0;
  logic        sop0 = 1'b0;
  edge_list_t  list = '0;
  logic        busy, overrun, busy0, overrun0;
  logic [11:0] frame_id, frame_id0;

  edge_list_streamer_if ifc ();
  edge_list_streamer_if if0 ();

  edge_list_streamer #(.EMIT_EMPTY(1'b1)) dut (
    .clk(clk), .reset(reset), .sop(sop), .measured_list(list),
    .out_if(ifc), .busy(busy), .overrun(overrun), .frame_id(frame_id)
  );

  edge_list_streamer #(.EMIT_EMPTY(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sop(sop0), .measured_list(list),
    .out_if(if0), .busy(busy0), .overrun(overrun0), .frame_id(frame_id0)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int fid_model = 0;
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] got_d[$];
  logic        got_l[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected burst derived directly from the list contents.
  function automatic void build_exp(input edge_list_t l, input int fid, input bit emit);
    int cnt = 0;
    exp_d.delete();
    exp_l.delete();
    while (cnt < N_ENTRIES && l[cnt] != 0) cnt++;
    if (cnt == 0 && !emit) return;
    exp_d.push_back(32'hA000_0000 | ((32'(fid) & 32'hFFF) << 16) | 32'(cnt));
    exp_l.push_back(cnt == 0);
    for (int i = 0; i < cnt; i++) begin
      int x = int'(l[i]);
      int g = 0;
      if (i < cnt - 1 && int'(l[i+1]) > x) g = int'(l[i+1]) - x;
      exp_d.push_back(32'h5000_0000 | (32'(i) << 23) | (32'(x) << 12) | 32'(g));
      exp_l.push_back(i == cnt - 1);
    end
  endfunction

  task automatic pulse_sop();
    @(negedge clk);
    sop = 1'b1;
    @(negedge clk);
    sop = 1'b0;
    list = '0;
    fid_model++;
    check("snap_busy", {31'd0, busy}, 32'd1);
    check("snap_valid", {31'd0, ifc.out_valid}, 32'd0);
  endtask

  // Accepts words until out_last; stalls words sa/sb for slen cycles or readies at random.
  task automatic drain(input int sa, input int sb, input int slen, input bit rnd, input int sop_word);
    int n = 0, sc = 0, cyc = 0;
    bit done = 0, held = 0, sop_done = 0, r;
    logic [31:0] hd;
    logic hl;
    got_d.delete();
    got_l.delete();
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      sop = 1'b0;
      if (held) begin
        check("hold_valid", {31'd0, ifc.out_valid}, 32'd1);
        check("hold_data", ifc.out_data, hd);
        check("hold_last", {31'd0, ifc.out_last}, {31'd0, hl});
      end
      held = 0;
      if (ifc.out_valid) begin
        if (n == sop_word && !sop_done) begin
          sop = 1'b1;
          sop_done = 1;
          fid_model++;
          for (int i = 0; i < N_ENTRIES; i++) list[i] = X_W'($urandom_range(1, 2047));
        end
        if (rnd) r = 1'($urandom_range(0, 1));
        else r = !((n == sa || n == sb) && sc < slen);
        ifc.out_ready = r;
        if (r) begin
          got_d.push_back(ifc.out_data);
          got_l.push_back(ifc.out_last);
          n++;
          sc = 0;
          if (ifc.out_last) done = 1;
        end else begin
          sc++;
          held = 1;
          hd = ifc.out_data;
          hl = ifc.out_last;
        end
      end else begin
        ifc.out_ready = 1'b0;
      end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    sop = 1'b0;
    ifc.out_ready = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, ifc.out_valid}, 32'd0);
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_nwords"}, 32'(got_d.size()), 32'(exp_d.size()));
    m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_data"}, got_d[i], exp_d[i]);
      check({tag, "_last"}, {31'd0, got_l[i]}, {31'd0, exp_l[i]});
    end
  endtask

  task automatic load_s1();
    list = '0;
    list[0] = 11'd100;
    list[1] = 11'd150;
    list[2] = 11'd400;
  endtask

  initial begin
    edge_list_t l;
    int cnt;
    ifc.out_ready = 1'b0;
    if0.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_data", ifc.out_data, 32'd0);
    check("rst_last", {31'd0, ifc.out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_fid", {20'd0, frame_id}, 32'd0);

    // Basic three-entry frame, then the same frame with stalls on header and entry 1.
    load_s1();
    l = list;
    pulse_sop();
    build_exp(l, fid_model, 1);
    drain(-1, -1, 0, 0, -1);
    compare("s1");
    check("s1_hdr", got_d[0], 32'hA001_0003);
    check("s1_e0", got_d[1], 32'h5006_4032);
    check("s1_e1", got_d[2], 32'h5089_60FA);
    check("s1_e2", got_d[3], 32'h5119_0000);

    load_s1();
    l = list;
    pulse_sop();
    build_exp(l, fid_model, 1);
    drain(0, 2, 5, 0, -1);
    compare("s2");

    // Empty list: header only on the EMIT_EMPTY=1 unit, a lone busy cycle on the other.
    list = '0;
    pulse_sop();
    build_exp('0, fid_model, 1);
    drain(-1, -1, 0, 0, -1);
    compare("s3");
    check("s3_hdr", got_d[0], 32'hA003_0000);
    @(negedge clk);
    sop0 = 1'b1;
    @(negedge clk);
    sop0 = 1'b0;
    check("s3e0_busy", {31'd0, busy0}, 32'd1);
    check("s3e0_valid_snap", {31'd0, if0.out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s3e0_idle_busy", {31'd0, busy0}, 32'd0);
      check("s3e0_no_valid", {31'd0, if0.out_valid}, 32'd0);
    end
    check("s3e0_fid", {20'd0, frame_id0}, 32'd1);

    // Full list with a constant spacing of 10.
    for (int i = 0; i < N_ENTRIES; i++) list[i] = X_W'(40 + 10 * i);
    l = list;
    pulse_sop();
    build_exp(l, fid_model, 1);
    drain(-1, -1, 0, 0, -1);
    compare("s4");

    // A second sop during entry 1 must not disturb the burst in flight.
    check("s5_overrun_before", {31'd0, overrun}, 32'd0);
    load_s1();
    l = list;
    pulse_sop();
    build_exp(l, fid_model - 0, 1);
    drain(-1, -1, 0, 0, 2);
    compare("s5");
    check("s5_overrun", {31'd0, overrun}, 32'd1);
    check("s5_fid", {20'd0, frame_id}, 32'(fid_model));

    // Randomized lists with garbage beyond the first zero and random backpressure.
    for (int f = 0; f < 12; f++) begin
      cnt = (f == 0) ? 1 : $urandom_range(0, N_ENTRIES);
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (i < cnt) list[i] = X_W'($urandom_range(1, 2047));
        else if (i == cnt) list[i] = '0;
        else list[i] = X_W'($urandom_range(0, 2047));
      end
      l = list;
      pulse_sop();
      build_exp(l, fid_model, 1);
      drain(-1, -1, 0, 1, -1);
      compare("rnd");
      check("rnd_fid", {20'd0, frame_id}, 32'(fid_model));
    end

    // Asynchronous reset in the middle of a stalled entry.
    for (int i = 0; i < N_ENTRIES; i++) list[i] = X_W'(40 + 10 * i);
    pulse_sop();
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    check("s6_in_entry", {28'd0, ifc.out_data[31:28]}, 32'h5);
    #2 reset = 1'b1;
    #1;
    check("s6_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("s6_busy", {31'd0, busy}, 32'd0);
    check("s6_fid", {20'd0, frame_id}, 32'd0);
    check("s6_overrun", {31'd0, overrun}, 32'd0);
    check("s6_data", ifc.out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fid_model = 0;
    load_s1();
    l = list;
    pulse_sop();
    build_exp(l, fid_model, 1);
    drain(-1, -1, 0, 0, -1);
    compare("s6");
    check("s6_hdr", got_d[0], 32'hA001_0003);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
